// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command-issue stage: opcodes, FSM states,
// the legality check and the width of one queued command record.
package alu_seq_pkg;

  localparam int ALU_W = 8;
  // One queued command: {op, a, b, acc_flag}
  localparam int CMD_W = 4 + 2 * ALU_W + 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_INC = 4'b0010;
  localparam logic [3:0] OP_DEC = 4'b0011;
  localparam logic [3:0] OP_CMP = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_REV = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_NOT = 4'b1110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_CMP, OP_SHR,
      OP_SHL, OP_REV, OP_AND, OP_OR, OP_XOR, OP_NOT: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags. Read data is the entry at
// the read pointer (show-ahead), so a pop consumes what rdata_o shows now.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage write; entries only become visible through count_q.
  // NOTE: the data array has no reset -- empty/full come from count_q, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap modulo DEPTH (power of two); count tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-issue stage in front of the 8-bit ALU: queues commands, drives
// registered operands/select, captures the ALU result one cycle later and
// keeps an accumulator that can replace operand A for chained operations.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W  // must equal ALU_W for the current ALU
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_acc,
  input  logic         acc_clr,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  input  logic         alu_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_cout,
  output logic         res_err,
  output logic [W-1:0] acc,
  output logic         busy
);

  state_e           state_q, state_d;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [W-1:0]     res_data_q, res_data_d;
  logic             res_cout_q, res_cout_d;
  logic             res_err_q, res_err_d;
  logic [W-1:0]     acc_q, acc_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;
  logic [3:0]       rd_op;
  logic [W-1:0]     rd_a;
  logic [W-1:0]     rd_b;
  logic             rd_acc;

  // Ready is forced low while reset is held, even though the FIFO is empty.
  assign cmd_ready = !fifo_full && !rst;
  assign fifo_push = cmd_valid && cmd_ready;
  assign {rd_op, rd_a, rd_b, rd_acc} = fifo_rdata;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({cmd_op, cmd_a, cmd_b, cmd_acc}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, pop/issue and result-capture logic.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    res_data_d = res_data_q;
    res_cout_d = res_cout_q;
    res_err_d  = res_err_q;
    acc_d      = acc_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          alu_a_d   = rd_acc ? acc_q : rd_a;
          alu_b_d   = rd_b;
          alu_sel_d = rd_op;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        state_d = RESULT;
        if (!is_legal_op(alu_sel_q)) begin
          res_data_d = '0;
          res_cout_d = 1'b0;
          res_err_d  = 1'b1;
        end else begin
          res_cout_d = alu_cout;
          res_err_d  = 1'b0;
          // Compare only defines the low three flag bits.
          res_data_d = (alu_sel_q == OP_CMP) ? {{(W - 3){1'b0}}, alu_out[2:0]}
                                             : alu_out;
          acc_d      = res_data_d;
        end
      end
      RESULT: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            // acc_q already holds the result captured on entry to RESULT.
            fifo_pop  = 1'b1;
            alu_a_d   = rd_acc ? acc_q : rd_a;
            alu_b_d   = rd_b;
            alu_sel_d = rd_op;
            state_d   = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear takes priority over a coinciding capture.
    if (acc_clr) acc_d = '0;
  end

  // State, operand, result and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      res_data_q <= '0;
      res_cout_q <= 1'b0;
      res_err_q  <= 1'b0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      res_data_q <= res_data_d;
      res_cout_q <= res_cout_d;
      res_err_q  <= res_err_d;
      acc_q      <= acc_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = (state_q == RESULT);
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;
  assign res_err   = res_err_q;
  assign acc       = acc_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-issue stage sitting directly upstream of the 8-bit ALU. It buffers ALU commands in a small FIFO, drives registered operands and select onto the ALU, and captures the ALU's combinational result one cycle later. Captured results are presented on a valid/ready result port, and an internal accumulator can substitute for operand A, which allows chained operations.

## Interface
- DEPTH, 4, command FIFO depth; power of two, ≥2
- W, 8, operand/result width; fixed at 8 for the current ALU
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept a command
- cmd_op  in  4  ALU select code
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- cmd_acc  in  1  1: use accumulator instead of cmd_a as operand A
- acc_clr  in  1  synchronous accumulator clear
- alu_a  out  W  registered operand A to ALU
- alu_b  out  W  registered operand B to ALU
- alu_sel  out  4  registered select to ALU
- alu_out  in  W  ALU result (combinational)
- alu_cout  in  1  ALU carry/borrow
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  W  captured result
- res_cout  out  1  captured carry/borrow
- res_err  out  1  command carried an illegal opcode
- acc  out  W  accumulator value
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- Legal opcodes: 0000 add, 0001 sub, 0010 inc, 0011 dec, 0100 cmp, 0101 shr, 0110 shl, 0111 rev, 1000 and, 1010 or, 1100 xor, 1110 not. All others are illegal.
- Push occurs when cmd_valid && cmd_ready. The FIFO stores {op, a, b, acc_flag}. cmd_ready = !full, and is 0 while rst is asserted.
- Operand A is resolved at pop time: acc if acc_flag, otherwise the stored a.
- FSM states: IDLE, EXEC, RESULT.
  - IDLE: if the FIFO is non-empty, pop and load alu_a/alu_b/alu_sel, then go to EXEC.
  - EXEC: at the clock edge, capture results and go to RESULT:
    - res_data = alu_out, res_cout = alu_cout, res_err = 0, acc = alu_out.
    - Exception for cmp (0100): res_data[7:3] are forced to 0, and acc is loaded with the masked value.
    - Exception for an illegal op: res_data = 0, res_cout = 0, res_err = 1, acc unchanged.
  - RESULT: res_valid = 1. On res_ready, if the FIFO is non-empty, pop and go to EXEC; otherwise go to IDLE.
- alu_a/alu_b/alu_sel hold their last values outside EXEC. res_data/res_cout/res_err are stable while res_valid is high.
- acc_clr sets acc to 0 at the next edge. If it coincides with an EXEC capture, clear wins (the result port still gets alu_out).
- A pop in RESULT→EXEC uses the acc just written at the EXEC→RESULT edge. This makes chained cmd_acc commands see the prior result.
- FIFO full with a pop in the same cycle: no push that cycle (cmd_ready was low). FIFO pointers wrap modulo DEPTH; occupancy count is $clog2(DEPTH)+1 bits.

## Timing
- Reset values: cmd_ready 0 during reset, 1 from the first cycle after release. alu_a/alu_b/alu_sel 0; res_valid/res_data/res_cout/res_err 0; acc 0; busy 0; state IDLE; FIFO empty.
- Latency when IDLE and empty: push at edge N; alu_* valid after edge N+1; res_valid high after edge N+2.
- Throughput with res_ready held high: one result every 2 cycles.
- Backpressure: with res_ready low, results hold indefinitely, the FIFO fills, and cmd_ready drops once DEPTH commands are queued.
- Reset mid-operation, asynchronous: queued commands and the pending result are discarded immediately. No res_valid is produced for them.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD … OP_NOT);
  - the FSM state typedef (IDLE/EXEC/RESULT);
  - function is_legal_op(op);
  - the command record width (4+2W+1).
- Sub-module alu_cmd_fifo holds the parameterised synchronous FIFO with full/empty. The sequencer top holds the FSM, operand/result registers and acc.

## Test plan
- Single add: push op 0000, a=0x0F, b=0x01 with res_ready=1 → res_valid two edges after push; res_data equals the ALU's alu_out; res_err=0.
- Chain: push 0000 a=5 b=3, then 0000 cmd_acc=1 b=2 → second operation drives alu_a = first result; acc = second alu_out.
- Cmp mask: op 0100, a=3, b=9, ALU model returns 0xF9 → res_data=0x01; acc=0x01.
- Illegal op 1011 → res_data=0, res_cout=0, res_err=1; acc unchanged; the next legal command is unaffected.
- Backpressure: res_ready=0, push 5 commands with DEPTH=4 → cmd_ready low after 4 queued; release res_ready → all results appear in order, 2 cycles apart.
- Reset with 3 queued and a result pending: assert rst → res_valid=0, acc=0 and busy=0 immediately; no stale result after release.
